// File: rtl/renode_pkg.sv
// Shared types for the Renode bridge message path.
// Adds the GPIO receiver FSM state and the packed message payload.
package renode_pkg;

  typedef enum logic [7:0] {
    invalid_action   = 8'd0,
    tick_clock       = 8'd1,
    write_request    = 8'd2,
    read_request     = 8'd3,
    reset_peripheral = 8'd4,
    interrupt        = 8'd5,
    ok_response      = 8'd6,
    error_response   = 8'd7
  } action_t;

  typedef logic [63:0] address_t;
  typedef logic [63:0] data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    RESPOND = 2'd2
  } gpio_state_e;

  typedef struct packed {
    action_t  action;
    address_t addr;
    data_t    data;
  } gpio_msg_t;

endpackage

// File: rtl/renode_msg_fifo.sv
// Small synchronous FIFO for bridge messages.
// Pointers carry one extra wrap bit to tell full from empty.
module renode_msg_fifo #(
  parameter int unsigned Depth = 4,
  parameter type elem_t = logic
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  elem_t                          push_data,
  input  logic                           pop,
  output elem_t                          pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(Depth+1)-1:0]     level
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = $clog2(Depth + 1);

  elem_t          mem_q [Depth];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign level    = LW'(wr_ptr_q - rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance, guarded against overflow and underflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/renode_gpio_receiver.sv
// Renode-to-HDL GPIO receiver: queues interrupt messages and drives lines.
// Optional feature macro: RENODE_LINE_PULSE_EN (self-clearing pulse lines).
module renode_gpio_receiver
  import renode_pkg::*;
#(
  parameter int unsigned LinesCount  = 1,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned PulseCycles = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              msg_valid,
  output logic                              msg_ready,
  input  action_t                           msg_action,
  input  address_t                          msg_addr,
  input  data_t                             msg_data,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic                              resp_error,
  output address_t                          resp_addr,
  output logic [LinesCount-1:0]             lines,
  output logic [$clog2(FifoDepth+1)-1:0]    fifo_level
);

  localparam int unsigned DataW = $bits(data_t);

  gpio_msg_t             fifo_din, fifo_dout;
  gpio_msg_t             held_q, held_d;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  gpio_state_e           state_q, state_d;
  logic [LinesCount-1:0] lines_q, lines_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_error_q, resp_error_d;
  address_t              resp_addr_q, resp_addr_d;
  logic                  msg_ok;

  assign msg_ready = !fifo_full && !rst;
  assign fifo_push = msg_valid && msg_ready;
  assign fifo_din  = '{action: msg_action, addr: msg_addr, data: msg_data};
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  // Full-width address compare so high address bits can never alias a line
  assign msg_ok = (held_q.action == interrupt) && (held_q.addr < address_t'(LinesCount));

  renode_msg_fifo #(
    .Depth  (FifoDepth),
    .elem_t (gpio_msg_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

`ifdef RENODE_LINE_PULSE_EN
  localparam int unsigned CntW = $clog2(PulseCycles + 1);
  logic [CntW-1:0] cnt_q [LinesCount];
  logic [CntW-1:0] cnt_d [LinesCount];
  logic            unused_data;
  assign unused_data = ^held_q.data[DataW-1:2];
`else
  logic            unused_data;
  assign unused_data = ^{held_q.data[DataW-1:1], (PulseCycles == 0)};
`endif

  // Next-state, decode and response logic
  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    lines_d      = lines_q;
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    resp_addr_d  = resp_addr_q;
`ifdef RENODE_LINE_PULSE_EN
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < LinesCount; i++) begin
      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
        if (cnt_q[i] == CntW'(1)) begin
          lines_d[i] = 1'b0;
        end
      end
    end
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          held_d  = fifo_dout;
          state_d = APPLY;
        end
      end
      APPLY: begin
        for (int unsigned i = 0; i < LinesCount; i++) begin
          if (msg_ok && (held_q.addr == address_t'(i))) begin
            lines_d[i] = held_q.data[0];
`ifdef RENODE_LINE_PULSE_EN
            // A pulse (re)loads the counter; any other write cancels it
            cnt_d[i] = (held_q.data[1:0] == 2'b11) ? CntW'(PulseCycles) : '0;
`endif
          end
        end
        resp_error_d = !msg_ok;
        resp_addr_d  = held_q.addr;
        resp_valid_d = 1'b1;
        state_d      = RESPOND;
      end
      RESPOND: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight message silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      held_q       <= '0;
      lines_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      lines_q      <= lines_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_addr_q  <= resp_addr_d;
    end
  end

`ifdef RENODE_LINE_PULSE_EN
  // Per-line pulse countdown registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LinesCount; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LinesCount; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`endif

  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_addr  = resp_addr_q;
  assign lines      = lines_q;

endmodule
